// File: rtl/multiply_shift_add_if.sv
// Operand/result bundle for the sequential fixed-point multiplier.
//   valid_in, multiplicand, multiplier : operands offered by the upstream master
//   ready                              : multiplier idle, operands will be taken
//   product, overflow                  : saturated result, held until next completion
//   valid_out                          : one-cycle pulse marking a fresh result
interface multiply_shift_add_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  valid_in;
  logic                  ready;
  logic [DATA_WIDTH-1:0] multiplicand;
  logic [DATA_WIDTH-1:0] multiplier;
  logic [DATA_WIDTH-1:0] product;
  logic                  valid_out;
  logic                  overflow;

  modport master (
    output valid_in, multiplicand, multiplier,
    input  ready, product, valid_out, overflow
  );

  modport slave (
    input  valid_in, multiplicand, multiplier,
    output ready, product, valid_out, overflow
  );
endinterface

// File: rtl/multiply_shift_add.sv
// Sequential signed fixed-point multiplier: product = sat((a*b) >>> FRAC_BITS),
// rounding toward zero, one partial product per clock.
//   clk   : single clock, posedge
//   reset : asynchronous, active-low
//   bus   : slave side of multiply_shift_add_if (valid_in/ready operand handshake,
//           product/overflow with a one-cycle valid_out pulse)
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | ready=1, waiting for valid_in; operands captured on accept
// S_MULT  | one shift-add iteration per clock, DATA_WIDTH iterations
// S_SCALE | drop fraction bits, saturate, load product/overflow
// S_DONE  | valid_out=1 for this single cycle
module multiply_shift_add #(
  parameter int DATA_WIDTH = 32,
  parameter int FRAC_BITS  = 10
) (
  input  logic                 clk,
  input  logic                 reset,
  multiply_shift_add_if.slave  bus
);

  localparam int CW = $clog2(DATA_WIDTH);
  localparam int AW = 2 * DATA_WIDTH;

  // Largest magnitudes representable for each result sign.
  localparam logic [AW-1:0] MAX_POS = {{(DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic [AW-1:0] MAX_NEG = {{DATA_WIDTH{1'b0}}, 1'b1, {(DATA_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_MULT  = 2'd1,
    S_SCALE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [AW-1:0]         r_acc;
  logic [AW-1:0]         r_mcand;
  logic [DATA_WIDTH-1:0] r_mplr;
  logic [CW-1:0]         r_cnt;
  logic                  r_sign;
  logic [DATA_WIDTH-1:0] r_product;
  logic                  r_overflow;

  logic                  w_accept;
  logic [DATA_WIDTH-1:0] w_abs_a;
  logic [DATA_WIDTH-1:0] w_abs_b;
  logic [AW-1:0]         w_mag;
  logic [DATA_WIDTH-1:0] w_sat_product;
  logic                  w_sat_overflow;

  assign w_accept = (r_state == S_IDLE) && bus.valid_in;

  // Unsigned magnitudes: the most negative operand maps to 2^(W-1) without wrapping.
  assign w_abs_a = bus.multiplicand[DATA_WIDTH-1] ? (~bus.multiplicand + 1'b1) : bus.multiplicand;
  assign w_abs_b = bus.multiplier[DATA_WIDTH-1]   ? (~bus.multiplier + 1'b1)   : bus.multiplier;

  // Truncating the magnitude gives round-toward-zero on the signed result.
  assign w_mag = r_acc >> FRAC_BITS;

  always_comb begin
    w_sat_product  = '0;
    w_sat_overflow = 1'b0;
    if (!r_sign) begin
      if (w_mag > MAX_POS) begin
        w_sat_product  = {1'b0, {(DATA_WIDTH-1){1'b1}}};
        w_sat_overflow = 1'b1;
      end else begin
        w_sat_product = w_mag[DATA_WIDTH-1:0];
      end
    end else begin
      if (w_mag > MAX_NEG) begin
        w_sat_product  = {1'b1, {(DATA_WIDTH-1){1'b0}}};
        w_sat_overflow = 1'b1;
      end else begin
        // A zero magnitude negates to zero, so no -0 can appear.
        w_sat_product = '0 - w_mag[DATA_WIDTH-1:0];
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (bus.valid_in) w_state_nxt = S_MULT;
      S_MULT:  if (r_cnt == '0)  w_state_nxt = S_SCALE;
      S_SCALE: w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_acc      <= '0;
      r_mcand    <= '0;
      r_mplr     <= '0;
      r_cnt      <= '0;
      r_sign     <= 1'b0;
      r_product  <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_accept) begin
        r_acc   <= '0;
        r_mcand <= {{DATA_WIDTH{1'b0}}, w_abs_a};
        r_mplr  <= w_abs_b;
        r_sign  <= bus.multiplicand[DATA_WIDTH-1] ^ bus.multiplier[DATA_WIDTH-1];
        // Down-counter: terminal count 0 marks the last of DATA_WIDTH iterations.
        r_cnt   <= CW'(DATA_WIDTH - 1);
      end else if (r_state == S_MULT) begin
        if (r_mplr[0]) begin
          r_acc <= r_acc + r_mcand;
        end
        r_mcand <= r_mcand << 1;
        r_mplr  <= r_mplr >> 1;
        r_cnt   <= r_cnt - 1'b1;
      end
      if (r_state == S_SCALE) begin
        r_product  <= w_sat_product;
        r_overflow <= w_sat_overflow;
      end
    end
  end

  assign bus.ready     = (r_state == S_IDLE);
  assign bus.valid_out = (r_state == S_DONE);
  assign bus.product   = r_product;
  assign bus.overflow  = r_overflow;

endmodule

// File: tb/tb_multiply_shift_add.sv
module tb_multiply_shift_add;

  localparam int DW   = 32;
  localparam int FRAC = 10;

  logic clk;
  logic reset;
  int   n_chk;
  int   n_pass;
  logic [DW-1:0] last_p;
  logic          last_o;

  multiply_shift_add_if #(.DATA_WIDTH(DW)) bus ();

  multiply_shift_add #(.DATA_WIDTH(DW), .FRAC_BITS(FRAC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference: exact product, integer divide (truncates toward zero), clamp to range.
  function automatic void ref_mul(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                  output logic [DW-1:0] p, output logic o);
    longint full;
    longint q;
    longint maxv;
    longint minv;
    maxv = (longint'(1) << (DW - 1)) - 1;
    minv = -(longint'(1) << (DW - 1));
    full = longint'($signed(a)) * longint'($signed(b));
    q    = full / (longint'(1) << FRAC);
    o    = 1'b0;
    if (q > maxv) begin
      q = maxv;
      o = 1'b1;
    end else if (q < minv) begin
      q = minv;
      o = 1'b1;
    end
    p = q[DW-1:0];
  endfunction

  // Offer operands, then watch 37 edges: latency, single pulse, ready, result hold.
  task automatic run_op(input logic [DW-1:0] a, input logic [DW-1:0] b, input bit inject);
    int            waitc;
    int            vcnt;
    int            lat;
    int            rdy_err;
    int            chg_err;
    logic [DW-1:0] exp_p;
    logic          exp_o;
    logic [DW-1:0] got_p;
    logic          got_o;
    ref_mul(a, b, exp_p, exp_o);
    waitc = 0;
    @(negedge clk);
    while (bus.ready !== 1'b1 && waitc < 100) begin
      @(negedge clk);
      waitc++;
    end
    if (bus.ready !== 1'b1) begin
      check("ready_wait", {63'd0, bus.ready}, 64'd1);
      return;
    end
    bus.valid_in     = 1'b1;
    bus.multiplicand = a;
    bus.multiplier   = b;
    @(posedge clk);
    #1;
    bus.valid_in     = 1'b0;
    bus.multiplicand = $urandom;
    bus.multiplier   = $urandom;
    vcnt = 0; lat = -1; rdy_err = 0; chg_err = 0;
    got_p = 'x; got_o = 1'bx;
    for (int n = 0; n <= 36; n++) begin
      if (n <= 33 && bus.ready !== 1'b0) rdy_err++;
      if (n >= 34 && bus.ready !== 1'b1) rdy_err++;
      if (bus.valid_out === 1'b1) begin
        vcnt++;
        if (lat < 0) lat = n + 1;
        got_p = bus.product;
        got_o = bus.overflow;
      end else if (n < 33 && (bus.product !== last_p || bus.overflow !== last_o)) begin
        chg_err++;
      end
      if (inject && n == 4) begin
        bus.valid_in     = 1'b1;
        bus.multiplicand = $urandom;
        bus.multiplier   = $urandom;
      end
      if (inject && n == 6) bus.valid_in = 1'b0;
      @(posedge clk);
      #1;
    end
    check("latency",   64'(lat), 64'd34);
    check("pulses",    64'(vcnt), 64'd1);
    check("ready",     64'(rdy_err), 64'd0);
    check("early_chg", 64'(chg_err), 64'd0);
    check("product",   {32'd0, got_p}, {32'd0, exp_p});
    check("overflow",  {63'd0, got_o}, {63'd0, exp_o});
    check("hold",      {31'd0, bus.overflow, bus.product}, {31'd0, exp_o, exp_p});
    last_p = exp_p;
    last_o = exp_o;
  endtask

  task automatic reset_mid_op(input logic [DW-1:0] a, input logic [DW-1:0] b);
    int vcnt;
    @(negedge clk);
    bus.valid_in     = 1'b1;
    bus.multiplicand = a;
    bus.multiplier   = b;
    @(posedge clk);
    #1;
    bus.valid_in = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    check("rst_ready",    {63'd0, bus.ready}, 64'd1);
    check("rst_product",  {32'd0, bus.product}, 64'd0);
    check("rst_overflow", {63'd0, bus.overflow}, 64'd0);
    check("rst_valid",    {63'd0, bus.valid_out}, 64'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    last_p = '0;
    last_o = 1'b0;
    vcnt = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (bus.valid_out === 1'b1) vcnt++;
    end
    check("rst_no_pulse", 64'(vcnt), 64'd0);
  endtask

  initial begin
    logic [DW-1:0] ra;
    logic [DW-1:0] rb;
    logic [DW-1:0] r;
    n_chk  = 0;
    n_pass = 0;
    last_p = '0;
    last_o = 1'b0;
    reset  = 1'b0;
    bus.valid_in     = 1'b0;
    bus.multiplicand = '0;
    bus.multiplier   = '0;
    repeat (3) @(posedge clk);
    #1;
    check("init_ready",    {63'd0, bus.ready}, 64'd1);
    check("init_valid",    {63'd0, bus.valid_out}, 64'd0);
    check("init_product",  {32'd0, bus.product}, 64'd0);
    check("init_overflow", {63'd0, bus.overflow}, 64'd0);
    @(negedge clk);
    reset = 1'b1;

    run_op(32'h0000_0400, 32'h0000_0800, 1'b0);
    run_op(32'hFFFF_FC00, 32'h0000_0600, 1'b0);
    run_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
    run_op(32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b0);
    run_op(32'h8000_0000, 32'h0000_0400, 1'b0);
    run_op(32'h0000_0000, 32'h8000_0000, 1'b0);
    run_op(32'h8000_0000, 32'h8000_0000, 1'b0);
    run_op(32'h8000_0000, 32'h0000_0401, 1'b0);
    run_op(32'h0000_0C00, 32'hFFFF_F800, 1'b1);

    reset_mid_op(32'h0001_2345, 32'hFFFF_8000);
    run_op(32'h0000_1400, 32'hFFFF_FA00, 1'b0);

    for (int i = 0; i < 20; i++) begin
      case ($urandom_range(0, 2))
        0: begin
          ra = $urandom;
          rb = $urandom;
        end
        1: begin
          r  = $urandom;
          ra = {{16{r[15]}}, r[15:0]};
          r  = $urandom;
          rb = {{16{r[15]}}, r[15:0]};
        end
        default: begin
          r  = $urandom;
          ra = {{12{r[19]}}, r[19:0]};
          r  = $urandom;
          rb = {{20{r[11]}}, r[11:0]};
        end
      endcase
      run_op(ra, rb, (i % 5) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
